// File: rtl/boot_rom_arbiter_pkg.sv
// Shared constants, helpers and types for the boot ROM arbiter.
package boot_rom_arbiter_pkg;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hBADA_CCE5;

  // Widest master index needed (NB_MASTERS is at most 8).
  localparam int MAX_IDX_W = 3;

  // Index width for n masters; a single master still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Registered response: which master gets it and whether it is an error.
  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [MAX_IDX_W-1:0] idx;
  } rsp_t;

endpackage

// File: rtl/boot_rom_arbiter_if.sv
// TCDM-style request/response bus between the requesters and the arbiter.
interface boot_rom_arbiter_if #(
  parameter int NB_MASTERS = 2
);
  logic [NB_MASTERS-1:0]       req;
  logic [NB_MASTERS-1:0][31:0] add;
  logic [NB_MASTERS-1:0]       wen;
  logic [NB_MASTERS-1:0]       gnt;
  logic [NB_MASTERS-1:0]       r_valid;
  logic [NB_MASTERS-1:0]       r_opc;
  logic [31:0]                 r_rdata;

  modport master (output req, add, wen, input gnt, r_valid, r_opc, r_rdata);
  modport slave  (input req, add, wen, output gnt, r_valid, r_opc, r_rdata);
endinterface

// File: rtl/boot_rom_rr_pick.sv
// Round-robin picker: first requester at or after the pointer wins.
module boot_rom_rr_pick
  import boot_rom_arbiter_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  localparam int IW = idx_width(NB_MASTERS)
) (
  input  logic [NB_MASTERS-1:0] req_i,
  input  logic [IW-1:0]         ptr_i,
  output logic [NB_MASTERS-1:0] gnt_o,
  output logic [IW-1:0]         idx_o,
  output logic                  vld_o
);

  // Scan masters starting at the pointer, wrapping around once.
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NB_MASTERS; k++) begin
      j = (int'(ptr_i) + k) % NB_MASTERS;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares the single-port boot ROM between NB_MASTERS requesters.
module boot_rom_arbiter
  import boot_rom_arbiter_pkg::*;
#(
  parameter int          NB_MASTERS     = 2,
  parameter int          ROM_ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  boot_rom_arbiter_if.slave         bus,
  output logic                      rom_cen_o,
  output logic [ROM_ADDR_WIDTH-3:0] rom_addr_o,
  input  logic [31:0]               rom_rdata_i
);

  localparam int IW = idx_width(NB_MASTERS);

  logic [IW-1:0]         ptr_q, ptr_d, win;
  logic [NB_MASTERS-1:0] req_m, gnt;
  logic                  any, hit;
  logic [31:0]           offset;
  logic                  unused_byte_bits;
  rsp_t                  rsp_q, rsp_d;

  // Requests are masked during reset so nothing is granted or accessed.
  assign req_m = rst_ni ? bus.req : '0;

  boot_rom_rr_pick #(.NB_MASTERS(NB_MASTERS)) u_pick (
    .req_i (req_m),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .vld_o (any)
  );

  assign bus.gnt = gnt;

  // Classify the winner: a read inside the window goes to the ROM, anything
  // else is still granted but answered with an error.
  always_comb begin
    offset     = bus.add[win] - BASE_ADDR;
    hit        = any && bus.wen[win] && (offset[31:ROM_ADDR_WIDTH] == '0);
    rom_cen_o  = ~hit;
    rom_addr_o = hit ? offset[ROM_ADDR_WIDTH-1:2] : '0;
  end

  // Byte lane bits never matter: the full word is always returned.
  assign unused_byte_bits = ^offset[1:0];

  // Pointer advances past the winner; holds when nobody requests.
  always_comb begin
    ptr_d = ptr_q;
    if (any) ptr_d = (win == IW'(NB_MASTERS - 1)) ? '0 : win + 1'b1;
    rsp_d.valid = any;
    rsp_d.err   = any && !hit;
    rsp_d.idx   = MAX_IDX_W'(win);
  end

  // Pointer and response stage; reset drops any outstanding response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      rsp_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rsp_q <= rsp_d;
    end
  end

  // Route the registered response to the master that was granted.
  always_comb begin
    bus.r_valid = '0;
    bus.r_opc   = '0;
    bus.r_rdata = '0;
    if (rst_ni && rsp_q.valid) begin
      for (int m = 0; m < NB_MASTERS; m++) begin
        if (rsp_q.idx == MAX_IDX_W'(m)) begin
          bus.r_valid[m] = 1'b1;
          bus.r_opc[m]   = rsp_q.err;
        end
      end
      bus.r_rdata = rsp_q.err ? ERR_RDATA : rom_rdata_i;
    end
  end

  // A waiting master must hold its request until granted.
  for (genvar m = 0; m < NB_MASTERS; m++) begin : g_chk
    a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.req[m] && !bus.gnt[m]) |=>
      (bus.req[m] && bus.add[m] == $past(bus.add[m]) && bus.wen[m] == $past(bus.wen[m])));
  end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Directed, table-driven bench for boot_rom_arbiter (2 masters, 8 KiB ROM).
module tb_boot_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_cen;
  logic [10:0] rom_addr;
  logic [31:0] rom_rdata = '0;
  logic [31:0] rom [2048];

  int nvec = 0;
  int nerr = 0;

  boot_rom_arbiter_if #(.NB_MASTERS(2)) bus ();

  boot_rom_arbiter #(
    .NB_MASTERS(2), .ROM_ADDR_WIDTH(13),
    .BASE_ADDR(32'h1A00_0000), .ERR_RDATA(32'hBADA_CCE5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .rom_cen_o(rom_cen), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata)
  );

  always #5 clk = ~clk;

  // ROM macro model: data one cycle after an enabled access.
  always @(posedge clk) if (!rom_cen) rom_rdata <= rom[rom_addr];

  typedef struct packed {
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic [1:0]  wen;
    logic [1:0]  gnt;
    logic        cen;
    logic [10:0] addr;
    logic [1:0]  rv, op;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [27];

  function automatic logic [31:0] wa(input int w);
    return 32'h1A00_0000 + 32'(w * 4);
  endfunction

  function automatic logic [31:0] rw(input int w);
    return (w == 4) ? 32'h0000_0297 : 32'hC0DE_0000 + 32'(w);
  endfunction

  function automatic vec_t mk(input logic r, input logic [1:0] req, input logic [31:0] a0, a1,
                              input logic [1:0] wen, gnt, input logic cen, input int ad,
                              input logic [1:0] rv, op, input logic [31:0] rd);
    return '{r, req, a0, a1, wen, gnt, cen, 11'(ad), rv, op, rd};
  endfunction

  task automatic check(input string nm, input logic [49:0] got, input logic [49:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got {gnt,cen,addr,rv,op,rd}=%h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [49:0] observe();
    return {bus.gnt, rom_cen, rom_addr, bus.r_valid, bus.r_opc, bus.r_rdata};
  endfunction

  localparam logic [31:0] ERR = 32'hBADA_CCE5;

  initial begin
    int c0, c1, w, pw;
    logic [31:0] prd;
    logic [1:0]  prv;
    for (int i = 0; i < 2048; i++) rom[i] = rw(i);
    bus.req = '0; bus.add = '0; bus.wen = 2'b11;

    //           rst req  a0                 a1                 wen    gnt   cen ad    rv     op     rd
    tbl[0]  = mk(0, 2'b11, wa(1),             wa(2),             2'b11, 2'b00, 1, 0,    2'b00, 2'b00, 0);
    tbl[1]  = mk(0, 2'b11, wa(1),             wa(2),             2'b11, 2'b00, 1, 0,    2'b00, 2'b00, 0);
    tbl[2]  = mk(1, 2'b01, 32'h1A00_0010,     0,                 2'b11, 2'b01, 0, 4,    2'b00, 2'b00, 0);
    tbl[3]  = mk(1, 2'b00, 0,                 0,                 2'b11, 2'b00, 1, 0,    2'b01, 2'b00, 32'h0000_0297);
    tbl[4]  = mk(1, 2'b11, wa(10),            wa(20),            2'b11, 2'b10, 0, 20,   2'b00, 2'b00, 0);
    tbl[5]  = mk(1, 2'b11, wa(10),            wa(21),            2'b11, 2'b01, 0, 10,   2'b10, 2'b00, rw(20));
    tbl[6]  = mk(1, 2'b11, wa(11),            wa(21),            2'b11, 2'b10, 0, 21,   2'b01, 2'b00, rw(10));
    tbl[7]  = mk(1, 2'b11, wa(11),            wa(22),            2'b11, 2'b01, 0, 11,   2'b10, 2'b00, rw(21));
    tbl[8]  = mk(1, 2'b11, wa(12),            wa(22),            2'b11, 2'b10, 0, 22,   2'b01, 2'b00, rw(11));
    tbl[9]  = mk(1, 2'b11, wa(12),            wa(23),            2'b11, 2'b01, 0, 12,   2'b10, 2'b00, rw(22));
    tbl[10] = mk(1, 2'b10, wa(12),            wa(23),            2'b11, 2'b10, 0, 23,   2'b01, 2'b00, rw(12));
    tbl[11] = mk(1, 2'b00, 0,                 0,                 2'b11, 2'b00, 1, 0,    2'b10, 2'b00, rw(23));
    tbl[12] = mk(1, 2'b10, 0,                 32'h1A00_0000,     2'b01, 2'b10, 1, 0,    2'b00, 2'b00, 0);
    tbl[13] = mk(1, 2'b00, 0,                 0,                 2'b11, 2'b00, 1, 0,    2'b10, 2'b10, ERR);
    tbl[14] = mk(1, 2'b01, 32'h1A00_2000,     0,                 2'b11, 2'b01, 1, 0,    2'b00, 2'b00, 0);
    tbl[15] = mk(1, 2'b01, 32'h19FF_FFFC,     0,                 2'b11, 2'b01, 1, 0,    2'b01, 2'b01, ERR);
    tbl[16] = mk(1, 2'b01, 32'h1A00_1FFC,     0,                 2'b11, 2'b01, 0, 2047, 2'b01, 2'b01, ERR);
    tbl[17] = mk(1, 2'b00, 0,                 0,                 2'b11, 2'b00, 1, 0,    2'b01, 2'b00, rw(2047));
    tbl[18] = mk(1, 2'b10, 0,                 32'h1A00_0013,     2'b11, 2'b10, 0, 4,    2'b00, 2'b00, 0);
    tbl[19] = mk(1, 2'b01, wa(5),             0,                 2'b11, 2'b01, 0, 5,    2'b10, 2'b00, 32'h0000_0297);
    tbl[20] = mk(1, 2'b00, 0,                 0,                 2'b11, 2'b00, 1, 0,    2'b01, 2'b00, rw(5));
    tbl[21] = mk(1, 2'b01, wa(6),             0,                 2'b11, 2'b01, 0, 6,    2'b00, 2'b00, 0);
    tbl[22] = mk(0, 2'b00, 0,                 0,                 2'b11, 2'b00, 1, 0,    2'b00, 2'b00, 0);
    tbl[23] = mk(0, 2'b11, wa(7),             wa(8),             2'b11, 2'b00, 1, 0,    2'b00, 2'b00, 0);
    tbl[24] = mk(1, 2'b11, wa(7),             wa(8),             2'b11, 2'b01, 0, 7,    2'b00, 2'b00, 0);
    tbl[25] = mk(1, 2'b10, 0,                 wa(8),             2'b11, 2'b10, 0, 8,    2'b01, 2'b00, rw(7));
    tbl[26] = mk(1, 2'b00, 0,                 0,                 2'b11, 2'b00, 1, 0,    2'b10, 2'b00, rw(8));

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst_n      = tbl[i].rst_n;
      bus.req    = tbl[i].req;
      bus.add[0] = tbl[i].a0;
      bus.add[1] = tbl[i].a1;
      bus.wen    = tbl[i].wen;
      #1;
      check($sformatf("vec%0d", i), observe(),
            {tbl[i].gnt, tbl[i].cen, tbl[i].addr, tbl[i].rv, tbl[i].op, tbl[i].rd});
    end

    // Continuous contention from pointer 0: strict alternation, no ROM bubble.
    c0 = 0; c1 = 0; prv = 2'b00; prd = '0; pw = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.req    = 2'b11;
      bus.wen    = 2'b11;
      bus.add[0] = wa(100 + c0);
      bus.add[1] = wa(200 + c1);
      #1;
      w = k % 2;
      pw = (w == 1) ? 200 + c1 : 100 + c0;
      check($sformatf("rr%0d", k), observe(),
            {2'b01 << w, 1'b0, 11'(pw), prv, 2'b00, prd});
      prv = 2'b01 << w;
      prd = rw(pw);
      if (w == 1) c1++; else c0++;
    end
    @(negedge clk);
    bus.req = 2'b00;
    #1;
    check("rr_tail", observe(), {2'b00, 1'b1, 11'd0, prv, 2'b00, prd});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
